// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates MIPS branch conditions, flags mispredictions,
// supplies the redirect PC and owns the 2-bit saturating branch history table.
module branch_resolve_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              r_valid,
  input  logic [2:0]        r_type,
  input  logic [PC_W-1:0]   r_pc,
  input  logic [DATA_W-1:0] r_a,
  input  logic [DATA_W-1:0] r_b,
  input  logic              r_pred_taken,
  input  logic [PC_W-1:0]   r_target,
  input  logic [PC_W-1:0]   r_fallthru,
  output logic              o_valid,
  output logic              o_taken,
  output logic              o_mispredict,
  output logic [PC_W-1:0]   o_redirect_pc,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  localparam int unsigned N_ENT = 2 ** IDX_W;

  localparam logic [2:0] T_BEQ  = 3'd1;
  localparam logic [2:0] T_BNE  = 3'd2;
  localparam logic [2:0] T_BGTZ = 3'd3;
  localparam logic [2:0] T_BLEZ = 3'd4;
  localparam logic [2:0] T_BGEZ = 3'd5;
  localparam logic [2:0] T_BLTZ = 3'd6;

  localparam logic [1:0] BHT_RESET = 2'b01;

  logic [1:0]       r_bht [N_ENT];

  logic             w_a_neg;
  logic             w_a_zero;
  logic             w_cond;
  logic             w_type_ok;
  logic             w_accept;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_r_idx;
  logic [IDX_W-1:0] w_f_idx;
  logic [1:0]       w_bht_cur;
  logic [1:0]       w_bht_nxt;
  logic             w_unused;

  assign w_r_idx = r_pc[IDX_W+1:2];
  assign w_f_idx = f_pc[IDX_W+1:2];

  // Untagged table: high PC bits and the byte offset do not participate.
  assign w_unused = ^{r_pc[PC_W-1:IDX_W+2], r_pc[1:0], f_pc[PC_W-1:IDX_W+2], f_pc[1:0]};

  // Read-old: fetch sees the table value before any same-cycle update.
  assign f_pred_taken = r_bht[w_f_idx][1];

  assign w_a_neg  = r_a[DATA_W-1];
  assign w_a_zero = (r_a == '0);

  always_comb begin
    w_cond    = 1'b0;
    w_type_ok = 1'b1;
    case (r_type)
      T_BEQ:   w_cond = (r_a == r_b);
      T_BNE:   w_cond = (r_a != r_b);
      T_BGTZ:  w_cond = !w_a_neg && !w_a_zero;
      T_BLEZ:  w_cond = w_a_neg || w_a_zero;
      T_BGEZ:  w_cond = !w_a_neg;
      T_BLTZ:  w_cond = w_a_neg;
      default: w_type_ok = 1'b0;
    endcase
  end

  assign w_accept     = r_valid && !stall && !flush && w_type_ok;
  assign w_mispredict = (w_cond != r_pred_taken);

  // Saturating 2-bit counter step for the resolved entry.
  always_comb begin
    w_bht_cur = r_bht[w_r_idx];
    w_bht_nxt = w_bht_cur;
    if (w_cond) begin
      if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'(1);
    end else begin
      if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_valid       <= 1'b0;
      o_taken       <= 1'b0;
      o_mispredict  <= 1'b0;
      o_redirect_pc <= '0;
    end else if (!stall) begin
      if (w_accept) begin
        o_valid       <= 1'b1;
        o_taken       <= w_cond;
        o_mispredict  <= w_mispredict;
        o_redirect_pc <= w_cond ? r_target : r_fallthru;
      end else begin
        o_valid      <= 1'b0;
        o_taken      <= 1'b0;
        o_mispredict <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(N_ENT); i++) begin
        r_bht[i] <= BHT_RESET;
      end
    end else if (w_accept) begin
      r_bht[w_r_idx] <= w_bht_nxt;
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (w_accept) begin
      if (stat_branches != '1) stat_branches <= stat_branches + CNT_W'(1);
      if (w_mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed test-plan steps plus
// randomized traffic checked against a behavioural reference model.
module tb_branch_resolve_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned CNT_W  = 32;
  localparam int          N_ENT  = 64;

  logic              clk = 1'b0;
  logic              resetn;
  logic              stall, flush;
  logic [PC_W-1:0]   f_pc;
  logic              f_pred_taken;
  logic              r_valid;
  logic [2:0]        r_type;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_pred_taken;
  logic [PC_W-1:0]   r_target, r_fallthru;
  logic              o_valid, o_taken, o_mispredict;
  logic [PC_W-1:0]   o_redirect_pc;
  logic [CNT_W-1:0]  stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_bht [N_ENT];
  bit          m_valid, m_taken, m_misp;
  logic [31:0] m_redir;
  longint      m_sb, m_sm;

  branch_resolve_unit #(
    .DATA_W(DATA_W), .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .r_valid(r_valid), .r_type(r_type), .r_pc(r_pc), .r_a(r_a), .r_b(r_b),
    .r_pred_taken(r_pred_taken), .r_target(r_target), .r_fallthru(r_fallthru),
    .o_valid(o_valid), .o_taken(o_taken), .o_mispredict(o_mispredict),
    .o_redirect_pc(o_redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return $signed(a) > 0;
      3'd4: return $signed(a) <= 0;
      3'd5: return $signed(a) >= 0;
      3'd6: return $signed(a) < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc / 4) % N_ENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_ENT; i++) m_bht[i] = 1;
    m_valid = 0; m_taken = 0; m_misp = 0; m_redir = '0;
    m_sb = 0; m_sm = 0;
  endtask

  task automatic drive(input bit v, input logic [2:0] t, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input bit pred,
                       input logic [31:0] tgt, input logic [31:0] ft,
                       input bit st, input bit fl, input logic [31:0] fpc);
    r_valid = v; r_type = t; r_pc = pc; r_a = a; r_b = b; r_pred_taken = pred;
    r_target = tgt; r_fallthru = ft; stall = st; flush = fl; f_pc = fpc;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".o_valid"}, 64'(o_valid), 64'(m_valid));
    chk({tag, ".o_taken"}, 64'(o_taken), 64'(m_taken));
    chk({tag, ".o_mispredict"}, 64'(o_mispredict), 64'(m_misp));
    chk({tag, ".o_redirect_pc"}, 64'(o_redirect_pc), 64'(m_redir));
    chk({tag, ".stat_branches"}, 64'(stat_branches), 64'(m_sb));
    chk({tag, ".stat_mispredicts"}, 64'(stat_mispredicts), 64'(m_sm));
    chk({tag, ".f_pred_taken"}, 64'(f_pred_taken), 64'(m_bht[pc_idx(f_pc)] >= 2));
  endtask

  // One clock: check the pre-edge prediction, advance the model, check after the edge.
  task automatic tick(input string tag);
    bit acc, t;
    int idx;
    #1;
    chk({tag, ".pre_pred"}, 64'(f_pred_taken), 64'(m_bht[pc_idx(f_pc)] >= 2));
    acc = r_valid && !stall && !flush && (r_type >= 1) && (r_type <= 6);
    if (!stall) begin
      if (acc) begin
        t = ref_cond(r_type, r_a, r_b);
        m_valid = 1; m_taken = t; m_misp = (t != r_pred_taken);
        m_redir = t ? r_target : r_fallthru;
        idx = pc_idx(r_pc);
        if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        if (m_sb < 64'hFFFF_FFFF) m_sb++;
        if (m_misp && m_sm < 64'hFFFF_FFFF) m_sm++;
      end else begin
        m_valid = 0; m_taken = 0; m_misp = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rt;
    model_reset();
    resetn = 1'b0;
    drive(1, 3'd1, 32'h0, 32'h5, 32'h5, 0, 32'h100, 32'h8, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // First transaction after reset
    drive(1, 3'd1, 32'h0, 32'h1234, 32'h1234, 0, 32'h100, 32'h8, 0, 0, 32'h0);
    tick("beq_first");
    chk("beq_first.const_redirect", 64'(o_redirect_pc), 64'h100);
    chk("beq_first.const_misp", 64'(o_mispredict), 64'h1);

    // Signed boundary cases
    drive(1, 3'd3, 32'h10, 32'h0, 32'h0, 0, 32'h200, 32'h14, 0, 0, 32'h10);
    tick("bgtz_zero");
    chk("bgtz_zero.const_taken", 64'(o_taken), 64'h0);
    drive(1, 3'd3, 32'h10, 32'h7FFF_FFFF, 32'h0, 0, 32'h200, 32'h14, 0, 0, 32'h10);
    tick("bgtz_max");
    chk("bgtz_max.const_taken", 64'(o_taken), 64'h1);
    drive(1, 3'd4, 32'h20, 32'h8000_0000, 32'h0, 1, 32'h300, 32'h24, 0, 0, 32'h20);
    tick("blez_min");
    drive(1, 3'd5, 32'h20, 32'h0, 32'h0, 0, 32'h300, 32'h24, 0, 0, 32'h20);
    tick("bgez_zero");
    drive(1, 3'd6, 32'h30, 32'hFFFF_FFFF, 32'h0, 1, 32'h400, 32'h34, 0, 0, 32'h30);
    tick("bltz_m1");
    drive(1, 3'd2, 32'h30, 32'hABCD, 32'hABCD, 0, 32'h400, 32'h34, 0, 0, 32'h30);
    tick("bne_eq");
    chk("bne_eq.const_taken", 64'(o_taken), 64'h0);

    // BHT saturation at 0x40; 0x44 must stay not-taken
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd1, 32'h40, 32'h1, 32'h1, 0, 32'h500, 32'h44, 0, 0, (i == 1) ? 32'h44 : 32'h40);
      tick("bht_up");
    end
    chk("bht_up.const_pred", 64'(f_pred_taken), 64'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd1, 32'h40, 32'h1, 32'h2, 1, 32'h500, 32'h44, 0, 0, (i == 2) ? 32'h44 : 32'h40);
      tick("bht_down");
    end
    chk("bht_down.const_pred", 64'(f_pred_taken), 64'h0);

    // Stall holds everything while a new request waits
    drive(1, 3'd5, 32'h80, 32'h5, 32'h0, 0, 32'h600, 32'h84, 0, 0, 32'h80);
    tick("stall_pre");
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd6, 32'h90, 32'h8000_0001, 32'h0, 0, 32'h700, 32'h94, 1, (i == 1), 32'h90);
      tick("stall_hold");
    end
    drive(1, 3'd6, 32'h90, 32'h8000_0001, 32'h0, 0, 32'h700, 32'h94, 0, 0, 32'h90);
    tick("stall_release");

    // Flush and invalid types have no side effects
    drive(1, 3'd1, 32'h40, 32'h7, 32'h7, 0, 32'h800, 32'h44, 0, 1, 32'h40);
    tick("flush");
    drive(1, 3'd7, 32'h40, 32'h7, 32'h7, 0, 32'h800, 32'h44, 0, 0, 32'h40);
    tick("type7");
    drive(1, 3'd0, 32'h40, 32'h7, 32'h7, 0, 32'h800, 32'h44, 0, 0, 32'h40);
    tick("type0");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rb = $urandom();
      case ($urandom_range(0, 4))
        0: ra = 32'h0;
        1: ra = rb;
        2: ra = 32'h8000_0000;
        3: ra = 32'h7FFF_FFFF;
        default: ra = $urandom();
      endcase
      rt = 3'($urandom_range(0, 7));
      drive($urandom_range(0, 9) != 0, rt, 32'($urandom_range(0, 15)) << 2, ra, rb,
            1'($urandom()), $urandom(), $urandom(),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            32'($urandom_range(0, 15)) << 2);
      tick("rand");
    end

    // Asynchronous reset between edges
    drive(1, 3'd1, 32'h40, 32'h3, 32'h3, 0, 32'h900, 32'h44, 0, 0, 32'h40);
    tick("pre_async");
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    for (int i = 0; i < N_ENT; i++) begin
      f_pc = 32'(i) << 2;
      #1;
      chk("async_rst.f_pred_all", 64'(f_pred_taken), 64'h0);
    end
    @(posedge clk);
    #1;
    check_outputs("async_rst_hold");
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 3'd2, 32'h4, 32'h1, 32'h2, 1, 32'hA00, 32'h8, 0, 0, 32'h4);
    tick("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
